// File: rtl/control_sequencer_if.sv
// Strobe/handshake bundle between the hardwired control sequencer (master)
// and the bus-based datapath plus memory (slave).
interface control_sequencer_if;
    logic [31:0] ir;
    logic        mem_ready;
    logic        resume;

    logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin;
    logic Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Cout;
    logic Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic [4:0]  alu_op;
    logic        run;
    logic        illegal;
    logic        mem_fault;
    logic [31:0] instr_count;

    modport master (
        input  ir, mem_ready, resume,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        output Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Cout,
        output Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
        output alu_op, run, illegal, mem_fault, instr_count
    );

    modport slave (
        output ir, mem_ready, resume,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin,
        input  Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Cout,
        input  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout,
        input  alu_op, run, illegal, mem_fault, instr_count
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, decode/execute T3-T7, memory-ready stalls.
// Optional retired-instruction counter enabled by defining PERF_COUNTER_EN.
module control_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int OPW         = 5
) (
    input logic                 Clock,
    input logic                 clear,
    control_sequencer_if.master bus
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    localparam logic [OPW-1:0] OP_LD   = OPW'(0);
    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_ST   = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
    localparam logic [OPW-1:0] OP_ALU9 = OPW'(11);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(15);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(16);
    localparam logic [OPW-1:0] OP_NOP  = OPW'(26);
    localparam logic [OPW-1:0] OP_HALT = OPW'(27);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU, C_MD, C_LDI, C_LD, C_ST, C_NOP, C_HALT, C_ILL
    } cls_t;

    state_t         state_q, state_d;
    cls_t           cls_q, cls_t3;
    logic [OPW-1:0] opcode, op_q;
    logic [WCW-1:0] wait_q, wait_d;
    logic           fault_q, fault_d;
    logic           stall, retire;

    function automatic cls_t decode(input logic [OPW-1:0] op);
        cls_t c;
        if (op >= OP_ADD && op <= OP_ALU9) c = C_ALU;
        else if (op == OP_MUL || op == OP_DIV) c = C_MD;
        else if (op == OP_LDI) c = C_LDI;
        else if (op == OP_LD) c = C_LD;
        else if (op == OP_ST) c = C_ST;
        else if (op == OP_NOP) c = C_NOP;
        else if (op == OP_HALT) c = C_HALT;
        else c = C_ILL;
        return c;
    endfunction

    // T3 is the one state that reads the live IR; later states use the latched class.
    assign opcode = bus.ir[31 -: OPW];
    assign cls_t3 = decode(opcode);

    always_ff @(posedge Clock) begin
        if (!clear) begin
            state_q <= S_RESET;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge Clock) begin
        if (state_q == S_T3) begin
            cls_q <= cls_t3;
            op_q  <= opcode;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        fault_d = fault_q;
        stall   = 1'b0;
        retire  = 1'b0;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_T0:    state_d = S_T1;
            S_T1:    if (bus.mem_ready) state_d = S_T2; else stall = 1'b1;
            S_T2:    state_d = S_T3;
            S_T3: begin
                case (cls_t3)
                    C_NOP, C_ILL: begin state_d = S_T0;   retire = 1'b1; end
                    C_HALT:       begin state_d = S_HALT; retire = 1'b1; end
                    default:      state_d = S_T4;
                endcase
            end
            S_T4: state_d = S_T5;
            S_T5: begin
                if (cls_q == C_ALU || cls_q == C_LDI) begin
                    state_d = S_T0;
                    retire  = 1'b1;
                end else begin
                    state_d = S_T6;
                end
            end
            S_T6: begin
                if (cls_q == C_MD) begin
                    state_d = S_T0;
                    retire  = 1'b1;
                end else if (cls_q == C_ST) begin
                    state_d = S_T7;
                end else if (bus.mem_ready) begin
                    state_d = S_T7;
                end else begin
                    stall = 1'b1;
                end
            end
            S_T7: begin
                if (cls_q == C_ST && !bus.mem_ready) begin
                    stall = 1'b1;
                end else begin
                    state_d = S_T0;
                    retire  = 1'b1;
                end
            end
            S_HALT:  if (bus.resume) state_d = S_T0;
            default: state_d = S_RESET;
        endcase
        if (stall) begin
            if (wait_q == WAIT_LAST) begin
                state_d = S_HALT;
                fault_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.PCout = 1'b0; bus.PCin = 1'b0; bus.IncPC = 1'b0; bus.MARin = 1'b0;
        bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.IRin = 1'b0; bus.Yin = 1'b0;
        bus.Zlowin = 1'b0; bus.Zhighin = 1'b0; bus.Zlowout = 1'b0; bus.Zhighout = 1'b0;
        bus.HIin = 1'b0; bus.LOin = 1'b0; bus.Cout = 1'b0; bus.Read = 1'b0;
        bus.Write = 1'b0; bus.Gra = 1'b0; bus.Grb = 1'b0; bus.Grc = 1'b0;
        bus.Rin = 1'b0; bus.Rout = 1'b0; bus.BAout = 1'b0;
        bus.alu_op  = '0;
        bus.illegal = 1'b0;
        bus.run     = (state_q != S_RESET) && (state_q != S_HALT);
        case (state_q)
            S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zlowin = 1'b1; end
            S_T1: begin bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1; end
            S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; end
            S_T3: begin
                case (cls_t3)
                    C_ALU:             begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    C_MD:              begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
                    C_LDI, C_LD, C_ST: begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
                    C_ILL:             bus.illegal = 1'b1;
                    default:           ;
                endcase
            end
            S_T4: begin
                bus.Zlowin = 1'b1;
                if (cls_q == C_ALU || cls_q == C_MD) begin
                    bus.Rout    = 1'b1;
                    bus.Zhighin = 1'b1;
                    bus.Grc     = (cls_q == C_ALU);
                    bus.Grb     = (cls_q == C_MD);
                    bus.alu_op  = op_q;
                end else begin
                    bus.Cout   = 1'b1;
                    bus.alu_op = OP_ADD;
                end
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                if (cls_q == C_ALU || cls_q == C_LDI) begin
                    bus.Gra = 1'b1;
                    bus.Rin = 1'b1;
                end else if (cls_q == C_MD) begin
                    bus.LOin = 1'b1;
                end else begin
                    bus.MARin = 1'b1;
                end
            end
            S_T6: begin
                if (cls_q == C_MD) begin
                    bus.Zhighout = 1'b1;
                    bus.HIin     = 1'b1;
                end else if (cls_q == C_LD) begin
                    bus.Read  = 1'b1;
                    bus.MDRin = 1'b1;
                end else begin
                    bus.Gra   = 1'b1;
                    bus.Rout  = 1'b1;
                    bus.MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (cls_q == C_LD) begin
                    bus.MDRout = 1'b1;
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                end else begin
                    bus.Write = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_fault = fault_q;

`ifdef PERF_COUNTER_EN
    logic [31:0] count_q;

    always_ff @(posedge Clock) begin
        if (!clear) count_q <= '0;
        else if (retire) count_q <= count_q + 32'd1;
    end

    assign bus.instr_count = count_q;
`else
    assign bus.instr_count = '0;
`endif
endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: stimulus pushes per-cycle expected strobes, a negedge monitor pops and compares.
module tb_control_sequencer;
    logic Clock;
    logic clear;

    control_sequencer_if bus();

    control_sequencer #(.MEM_TIMEOUT(15), .OPW(5)) dut (
        .Clock(Clock),
        .clear(clear),
        .bus  (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [22:0] PCO = 23'd1 << 0;
    localparam logic [22:0] PCI = 23'd1 << 1;
    localparam logic [22:0] INC = 23'd1 << 2;
    localparam logic [22:0] MAI = 23'd1 << 3;
    localparam logic [22:0] MDI = 23'd1 << 4;
    localparam logic [22:0] MDO = 23'd1 << 5;
    localparam logic [22:0] IRI = 23'd1 << 6;
    localparam logic [22:0] YIN = 23'd1 << 7;
    localparam logic [22:0] ZLI = 23'd1 << 8;
    localparam logic [22:0] ZHI = 23'd1 << 9;
    localparam logic [22:0] ZLO = 23'd1 << 10;
    localparam logic [22:0] ZHO = 23'd1 << 11;
    localparam logic [22:0] HII = 23'd1 << 12;
    localparam logic [22:0] LOI = 23'd1 << 13;
    localparam logic [22:0] CO  = 23'd1 << 14;
    localparam logic [22:0] RD  = 23'd1 << 15;
    localparam logic [22:0] WR  = 23'd1 << 16;
    localparam logic [22:0] GA  = 23'd1 << 17;
    localparam logic [22:0] GB  = 23'd1 << 18;
    localparam logic [22:0] GC  = 23'd1 << 19;
    localparam logic [22:0] RIN = 23'd1 << 20;
    localparam logic [22:0] ROU = 23'd1 << 21;
    localparam logic [22:0] BAO = 23'd1 << 22;

`ifdef PERF_COUNTER_EN
    localparam logic [31:0] CNT_STEP = 32'd1;
`else
    localparam logic [31:0] CNT_STEP = 32'd0;
`endif

    typedef struct {
        string       nm;
        logic [22:0] s;
        logic [4:0]  a;
        logic        r;
        logic        il;
        logic        f;
        logic [31:0] c;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        exp_fault = 1'b0;
    logic [31:0] exp_cnt = 32'd0;
    logic [22:0] act_s;

    assign act_s = {bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.Write,
                    bus.Read, bus.Cout, bus.LOin, bus.HIin, bus.Zhighout, bus.Zlowout,
                    bus.Zhighin, bus.Zlowin, bus.Yin, bus.IRin, bus.MDRout, bus.MDRin,
                    bus.MARin, bus.IncPC, bus.PCin, bus.PCout};

    always @(negedge Clock) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (act_s !== e.s || bus.alu_op !== e.a || bus.run !== e.r ||
                bus.illegal !== e.il || bus.mem_fault !== e.f || bus.instr_count !== e.c) begin
                errors++;
                $display("FAIL %s @%0t: got strb=%h alu=%0d run=%b ill=%b flt=%b cnt=%0d, want strb=%h alu=%0d run=%b ill=%b flt=%b cnt=%0d",
                         e.nm, $time, act_s, bus.alu_op, bus.run, bus.illegal, bus.mem_fault,
                         bus.instr_count, e.s, e.a, e.r, e.il, e.f, e.c);
            end
        end
    end

    task automatic cyc(input string nm, input logic [22:0] s, input logic [4:0] a,
                       input logic r, input logic il);
        exp_t e;
        e.nm = nm; e.s = s; e.a = a; e.r = r; e.il = il; e.f = exp_fault; e.c = exp_cnt;
        sb.push_back(e);
        @(posedge Clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] instr, input int stall);
        bus.mem_ready = 1'b1;
        cyc("T0", PCO | MAI | INC | ZLI, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < stall; i++) begin
            bus.mem_ready = 1'b0;
            cyc("T1_wait", ZLO | PCI | RD | MDI, 5'd0, 1'b1, 1'b0);
        end
        bus.mem_ready = 1'b1;
        cyc("T1", ZLO | PCI | RD | MDI, 5'd0, 1'b1, 1'b0);
        bus.ir = instr;
        cyc("T2", MDO | IRI, 5'd0, 1'b1, 1'b0);
    endtask

    task automatic run_alu(input logic [31:0] instr, input logic [4:0] op);
        fetch(instr, 0);
        cyc("ALU_T3", GB | ROU | YIN, 5'd0, 1'b1, 1'b0);
        cyc("ALU_T4", GC | ROU | ZLI | ZHI, op, 1'b1, 1'b0);
        cyc("ALU_T5", ZLO | GA | RIN, 5'd0, 1'b1, 1'b0);
        exp_cnt += CNT_STEP;
    endtask

    task automatic run_md(input logic [31:0] instr, input logic [4:0] op);
        fetch(instr, 0);
        cyc("MD_T3", GA | ROU | YIN, 5'd0, 1'b1, 1'b0);
        cyc("MD_T4", GB | ROU | ZLI | ZHI, op, 1'b1, 1'b0);
        cyc("MD_T5", ZLO | LOI, 5'd0, 1'b1, 1'b0);
        cyc("MD_T6", ZHO | HII, 5'd0, 1'b1, 1'b0);
        exp_cnt += CNT_STEP;
    endtask

    task automatic run_ba(input logic [31:0] instr);
        cyc("BA_T3", GB | BAO | YIN, 5'd0, 1'b1, 1'b0);
        cyc("BA_T4", CO | ZLI, 5'd3, 1'b1, 1'b0);
    endtask

    task automatic run_ld(input logic [31:0] instr, input int stall);
        fetch(instr, 0);
        run_ba(instr);
        cyc("LD_T5", ZLO | MAI, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < stall; i++) begin
            bus.mem_ready = 1'b0;
            cyc("LD_T6_wait", RD | MDI, 5'd0, 1'b1, 1'b0);
        end
        bus.mem_ready = 1'b1;
        cyc("LD_T6", RD | MDI, 5'd0, 1'b1, 1'b0);
        cyc("LD_T7", MDO | GA | RIN, 5'd0, 1'b1, 1'b0);
        exp_cnt += CNT_STEP;
    endtask

    task automatic run_st(input logic [31:0] instr, input int stall);
        fetch(instr, 0);
        run_ba(instr);
        cyc("ST_T5", ZLO | MAI, 5'd0, 1'b1, 1'b0);
        cyc("ST_T6", GA | ROU | MDI, 5'd0, 1'b1, 1'b0);
        for (int i = 0; i < stall; i++) begin
            bus.mem_ready = 1'b0;
            cyc("ST_T7_wait", WR, 5'd0, 1'b1, 1'b0);
        end
        bus.mem_ready = 1'b1;
        cyc("ST_T7", WR, 5'd0, 1'b1, 1'b0);
        exp_cnt += CNT_STEP;
    endtask

    initial begin
        clear = 1'b0;
        bus.ir = 32'd0;
        bus.mem_ready = 1'b1;
        bus.resume = 1'b0;
        @(posedge Clock);
        #1;

        cyc("reset0", 23'd0, 5'd0, 1'b0, 1'b0);
        cyc("reset1", 23'd0, 5'd0, 1'b0, 1'b0);
        clear = 1'b1;
        cyc("reset_exit", 23'd0, 5'd0, 1'b0, 1'b0);

        bus.resume = 1'b1;
        run_alu(32'h191A0000, 5'd3);
        bus.resume = 1'b0;
        run_ld(32'h00800045, 3);
        run_st(32'h10000000, 1);
        run_md(32'h78000000, 5'd15);
        run_md(32'h80000000, 5'd16);

        fetch(32'h08000000, 2);
        run_ba(32'h08000000);
        cyc("LDI_T5", ZLO | GA | RIN, 5'd0, 1'b1, 1'b0);
        exp_cnt += CNT_STEP;

        fetch(32'hD0000000, 0);
        cyc("NOP_T3", 23'd0, 5'd0, 1'b1, 1'b0);
        exp_cnt += CNT_STEP;

        fetch(32'hF8000000, 0);
        cyc("ILL_T3", 23'd0, 5'd0, 1'b1, 1'b1);
        exp_cnt += CNT_STEP;

        fetch(32'hD8000000, 0);
        cyc("HALT_T3", 23'd0, 5'd0, 1'b1, 1'b0);
        exp_cnt += CNT_STEP;
        cyc("halted0", 23'd0, 5'd0, 1'b0, 1'b0);
        cyc("halted1", 23'd0, 5'd0, 1'b0, 1'b0);
        bus.resume = 1'b1;
        cyc("halt_resume", 23'd0, 5'd0, 1'b0, 1'b0);
        bus.resume = 1'b0;

        cyc("T0", PCO | MAI | INC | ZLI, 5'd0, 1'b1, 1'b0);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) cyc("T1_timeout", ZLO | PCI | RD | MDI, 5'd0, 1'b1, 1'b0);
        exp_fault = 1'b1;
        bus.mem_ready = 1'b1;
        cyc("fault_halt0", 23'd0, 5'd0, 1'b0, 1'b0);
        cyc("fault_halt1", 23'd0, 5'd0, 1'b0, 1'b0);
        bus.resume = 1'b1;
        cyc("fault_resume", 23'd0, 5'd0, 1'b0, 1'b0);
        bus.resume = 1'b0;

        fetch(32'h191A0000, 0);
        cyc("ALU_T3", GB | ROU | YIN, 5'd0, 1'b1, 1'b0);
        clear = 1'b0;
        cyc("ALU_T4_clr", GC | ROU | ZLI | ZHI, 5'd3, 1'b1, 1'b0);
        exp_fault = 1'b0;
        exp_cnt = 32'd0;
        clear = 1'b1;
        cyc("mid_clear", 23'd0, 5'd0, 1'b0, 1'b0);
        cyc("T0_after_clear", PCO | MAI | INC | ZLI, 5'd0, 1'b1, 1'b0);
        cyc("T1", ZLO | PCI | RD | MDI, 5'd0, 1'b1, 1'b0);
        bus.ir = 32'hD8000000;
        cyc("T2", MDO | IRI, 5'd0, 1'b1, 1'b0);
        cyc("HALT_T3", 23'd0, 5'd0, 1'b1, 1'b0);
        exp_cnt += CNT_STEP;
        clear = 1'b0;
        bus.resume = 1'b1;
        cyc("halt_clr_resume", 23'd0, 5'd0, 1'b0, 1'b0);
        exp_cnt = 32'd0;
        clear = 1'b1;
        bus.resume = 1'b0;
        cyc("clear_beats_resume", 23'd0, 5'd0, 1'b0, 1'b0);
        cyc("T0_final", PCO | MAI | INC | ZLI, 5'd0, 1'b1, 1'b0);

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge Clock);
        #1;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
